ifmap_write_controller: RTL

Upstream neighbour of the IFMap read address generator. Accepts a valid/ready input stream and writes it into the circular IFMap scratchpad (IFMAP_DEPTH entries). It tracks occupancy and publishes the current complete window as start_data/end_data/window_valid. It frees a window's entries when the read side pulses release, which is driven from the reader's at_end_data.

---
 rtl/ifmap_write_controller_pkg.sv | 19 +
 rtl/ifmap_write_controller_mod_counter.sv | 20 ++
 rtl/ifmap_write_controller.sv | 102 ++++++++++
 3 files changed

// File: rtl/ifmap_write_controller_pkg.sv
// ifmap_write_controller_pkg: shared IFMap scratchpad sizing, state encoding and wrap helpers
package ifmap_write_controller_pkg;
    localparam int IFMAP_ADDR_WIDTH = 4;
    localparam int IFMAP_DEPTH = 16;
    localparam int DATA_WIDTH = 16;
    localparam int LEN_WIDTH = IFMAP_ADDR_WIDTH + 1;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_READY = 2'd2,
        S_HOLD  = 2'd3
    } state_e;
    function automatic logic [IFMAP_ADDR_WIDTH-1:0] wrap_inc(input logic [IFMAP_ADDR_WIDTH-1:0] a);
        return (a == IFMAP_ADDR_WIDTH'(IFMAP_DEPTH - 1)) ? '0 : a + IFMAP_ADDR_WIDTH'(1);
    endfunction
    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] l);
        return (l == '0 || l > LEN_WIDTH'(IFMAP_DEPTH)) ? LEN_WIDTH'(IFMAP_DEPTH) : l;
    endfunction
endpackage

// File: rtl/ifmap_write_controller_mod_counter.sv
// mod_counter: scratchpad address counter wrapping at IFMAP_DEPTH; load+enable yields wrap_inc(load value)
module mod_counter
    import ifmap_write_controller_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic                        load_i,
    input  logic [IFMAP_ADDR_WIDTH-1:0] load_val_i,
    input  logic                        en_i,
    output logic [IFMAP_ADDR_WIDTH-1:0] cnt_o
);
    logic [IFMAP_ADDR_WIDTH-1:0] cnt_q, cnt_d, src;
    assign src = load_i ? load_val_i : cnt_q;
    assign cnt_d = clr_i ? '0 : en_i ? wrap_inc(src) : src;
    always_ff @(posedge clk_i) begin
        cnt_q <= !rst_i ? '0 : cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/ifmap_write_controller.sv
// ifmap_write_controller: streams words into the circular IFMap scratchpad and publishes
// complete windows to the reader, freeing each window when the reader releases it.
module ifmap_write_controller
    import ifmap_write_controller_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [LEN_WIDTH-1:0]        row_len_i,
    input  logic                        in_valid_i,
    input  logic [DATA_WIDTH-1:0]       in_data_i,
    input  logic                        in_last_i,
    output logic                        in_ready_o,
    output logic                        wen_o,
    output logic [IFMAP_ADDR_WIDTH-1:0] waddr_o,
    output logic [DATA_WIDTH-1:0]       wdata_o,
    input  logic                        release_i,
    output logic [IFMAP_ADDR_WIDTH-1:0] start_data_o,
    output logic [IFMAP_ADDR_WIDTH-1:0] end_data_o,
    output logic                        window_valid_o,
    output logic [LEN_WIDTH-1:0]        count_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic                        err_o
);
    state_e state_q;
    logic [IFMAP_ADDR_WIDTH-1:0] end_data_q, next_end_q;
    logic [LEN_WIDTH-1:0] count_q, count_d, eff_len_q, cur_len_q, next_len_q, open_cnt_q, words;
    logic err_q, pend_q, accept, close, rel_ok;

    assign full_o = count_q == LEN_WIDTH'(IFMAP_DEPTH);
    assign empty_o = count_q == '0;
    assign window_valid_o = state_q == S_READY || state_q == S_HOLD;
    assign in_ready_o = !start_i && !full_o && (state_q == S_FILL || state_q == S_READY);
    assign accept = in_valid_i && in_ready_o;
    assign words = open_cnt_q + LEN_WIDTH'(1);
    assign close = accept && (in_last_i || words == eff_len_q);
    assign rel_ok = release_i && window_valid_o;
    assign count_d = count_q + LEN_WIDTH'(accept) - (rel_ok ? cur_len_q : '0);
    assign wen_o = accept;
    assign wdata_o = in_data_i;
    assign end_data_o = end_data_q;
    assign count_o = count_q;
    assign err_o = err_q;

    mod_counter u_wptr (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(start_i), .load_i(1'b0),
        .load_val_i('0), .en_i(accept), .cnt_o(waddr_o)
    );
    mod_counter u_start (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(start_i), .load_i(rel_ok),
        .load_val_i(end_data_q), .en_i(rel_ok), .cnt_o(start_data_o)
    );

    // pend_q: a window closed in the same cycle READY was released; it goes live after one FILL cycle
    always_ff @(posedge clk_i) begin
        if (!rst_i || start_i) begin
            state_q    <= rst_i ? S_FILL : S_IDLE;
            eff_len_q  <= rst_i ? clamp_len(row_len_i) : LEN_WIDTH'(IFMAP_DEPTH);
            end_data_q <= '0;
            next_end_q <= '0;
            count_q    <= '0;
            cur_len_q  <= '0;
            next_len_q <= '0;
            open_cnt_q <= '0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            count_q <= count_d;
            if (release_i && !window_valid_o) err_q <= 1'b1;
            if (accept) open_cnt_q <= close ? '0 : words;
            if (close && (state_q != S_FILL || pend_q)) begin
                next_end_q <= waddr_o;
                next_len_q <= words;
            end
            case (state_q)
                S_FILL: begin
                    if (pend_q || close) begin
                        end_data_q <= pend_q ? next_end_q : waddr_o;
                        cur_len_q  <= pend_q ? next_len_q : words;
                        state_q    <= (pend_q && close) ? S_HOLD : S_READY;
                    end
                    pend_q <= 1'b0;
                end
                S_READY: begin
                    if (release_i) begin
                        state_q <= S_FILL;
                        pend_q  <= close;
                    end else if (close) state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (release_i) begin
                        end_data_q <= next_end_q;
                        cur_len_q  <= next_len_q;
                        state_q    <= S_READY;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
